// File: rtl/bch74_pkg.sv
// rtl/bch74_pkg.sv - BCH(7,4) code constants, FSM state type and helper functions
//
// Shared by the serial decoder, the syndrome corrector and reference models.
// Bit positions are codeword positions: c[6:3] = data, c[2:0] = parity.

package bch74_pkg;

  localparam int N = 7;
  localparam int K = 4;
  localparam int R = 3;

  // H column {s2,s1,s0} contributed by codeword bit c[p]; index = p.
  localparam logic [N-1:0][R-1:0] H_COL = {
    3'b110,  // c6
    3'b101,  // c5
    3'b011,  // c4
    3'b111,  // c3
    3'b100,  // c2
    3'b010,  // c1
    3'b001   // c0
  };

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Position of the single flipped bit for a nonzero syndrome; 7 means "none".
  function automatic logic [2:0] syn_to_pos(input logic [R-1:0] syn);
    logic [2:0] pos;
    case (syn)
      3'b110:  pos = 3'd6;
      3'b101:  pos = 3'd5;
      3'b011:  pos = 3'd4;
      3'b111:  pos = 3'd3;
      3'b100:  pos = 3'd2;
      3'b010:  pos = 3'd1;
      3'b001:  pos = 3'd0;
      default: pos = 3'd7;
    endcase
    return pos;
  endfunction

  // Full-word syndrome, for parallel users of the corrector.
  function automatic logic [R-1:0] syndrome(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int p = 0; p < N; p++) begin
      if (c[p]) s = s ^ H_COL[p];
    end
    return s;
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    return {d,
            d[3] ^ d[2] ^ d[0],
            d[3] ^ d[1] ^ d[0],
            d[2] ^ d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/bch74_syndrome_corrector.sv
// rtl/bch74_syndrome_corrector.sv - combinational BCH(7,4) single-error corrector
//
// Ports:
//   word            in  7  raw received codeword c[6:0]
//   syndrome        in  3  syndrome of word (serial users accumulate it on the fly,
//                          parallel users can take bch74_pkg::syndrome(word))
//   data            out 4  corrected c[6:3]
//   error_detected  out 1  syndrome nonzero
//   error_corrected out 1  a bit was flipped

module bch74_syndrome_corrector
  import bch74_pkg::*;
(
  input  logic [N-1:0] word,
  input  logic [R-1:0] syndrome,
  output logic [K-1:0] data,
  output logic         error_detected,
  output logic         error_corrected
);

  logic [2:0]   pos;
  logic [N-1:0] flip;
  logic [N-1:0] fixed;

  always_comb begin
    pos   = syn_to_pos(syndrome);
    flip  = (syndrome != '0) ? (N'(1) << pos) : '0;
    fixed = word ^ flip;
    data  = fixed[N-1:N-K];
    error_detected  = (syndrome != '0);
    // Every nonzero syndrome names a bit position, so a detection is always a correction.
    error_corrected = (syndrome != '0);
  end

endmodule

// File: rtl/bch74_serial_decoder.sv
// rtl/bch74_serial_decoder.sv - bit-serial BCH(7,4) decoder with one-entry output register
//
// Optional macro BCH74_DECODER_STATS_EN adds saturating stat_* counters.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_bit/s_sof serial input bit, start-of-frame marks codeword bit 0
//   s_ready             serial bit accepted this cycle
//   m_valid/m_ready     decoded word handshake
//   m_data              corrected data c[6:3]
//   m_err_detected      nonzero syndrome for this word
//   m_err_corrected     a bit was flipped for this word
//   stat_frames         (stats) words loaded into the output register
//   stat_corrected      (stats) loaded words with nonzero syndrome
//   stat_aborts         (stats) frames aborted by s_sof mid-frame
//
// Parameter MSB_FIRST: 1 = first serial bit is c[6], 0 = first serial bit is c[0].

module bch74_serial_decoder
  import bch74_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic         s_bit,
  input  logic         s_sof,
  output logic         s_ready,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [K-1:0] m_data,
  output logic         m_err_detected,
`ifdef BCH74_DECODER_STATS_EN
  output logic [15:0]  stat_frames,
  output logic [15:0]  stat_corrected,
  output logic [7:0]   stat_aborts,
`endif
  output logic         m_err_corrected
);

  state_t       state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [R-1:0] syn_q, syn_d;
  logic [N-1:0] buf_q, buf_d;

  logic         accept;
  logic         restart;
  logic         last_bit;
  logic         load;
  logic [2:0]   idx;
  logic [2:0]   pos;
  logic [N-1:0] base_buf;
  logic [R-1:0] base_syn;
  logic [N-1:0] shifted;
  logic [R-1:0] syn_acc;

  logic [K-1:0] dec_data;
  logic         dec_detected;
  logic         dec_corrected;

  // The 7th bit stalls only when the output register is full and not draining.
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == 3'd6);
  assign s_ready  = !(last_bit && m_valid && !m_ready);
  assign accept   = s_valid && s_ready;

  // A bit starts a fresh frame when it carries sof (from IDLE, or aborting SHIFT);
  // in that case accumulation starts from an empty buffer and zero syndrome.
  assign restart  = s_sof || (state_q != SHIFT);

  always_comb begin
    idx      = restart ? 3'd0 : bit_cnt_q;
    pos      = MSB_FIRST ? (3'd6 - idx) : idx;
    base_buf = restart ? '0 : buf_q;
    base_syn = restart ? '0 : syn_q;
    shifted  = MSB_FIRST ? {base_buf[N-2:0], s_bit} : {s_bit, base_buf[N-1:1]};
    syn_acc  = s_bit ? (base_syn ^ H_COL[pos]) : base_syn;
  end

  // Fed with the word and syndrome including the bit on the wire, so the result
  // is ready in the same cycle the 7th bit is accepted.
  bch74_syndrome_corrector u_corrector (
    .word            (shifted),
    .syndrome        (syn_acc),
    .data            (dec_data),
    .error_detected  (dec_detected),
    .error_corrected (dec_corrected)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    syn_d     = syn_q;
    buf_d     = buf_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && s_sof) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd1;
          syn_d     = syn_acc;
          buf_d     = shifted;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (s_sof) begin
            bit_cnt_d = 3'd1;
            syn_d     = syn_acc;
            buf_d     = shifted;
          end else if (bit_cnt_q == 3'd6) begin
            load      = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            syn_d     = '0;
            buf_d     = shifted;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            syn_d     = syn_acc;
            buf_d     = shifted;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      syn_q     <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      syn_q     <= syn_d;
      buf_q     <= buf_d;
    end
  end

  // A load in the same cycle as a drain wins, keeping m_valid high with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_err_detected  <= 1'b0;
      m_err_corrected <= 1'b0;
    end else if (load) begin
      m_valid         <= 1'b1;
      m_data          <= dec_data;
      m_err_detected  <= dec_detected;
      m_err_corrected <= dec_corrected;
    end else if (m_ready) begin
      m_valid         <= 1'b0;
    end
  end

`ifdef BCH74_DECODER_STATS_EN
  logic abort_frame;
  assign abort_frame = (state_q == SHIFT) && accept && s_sof;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames    <= '0;
      stat_corrected <= '0;
      stat_aborts    <= '0;
    end else begin
      if (load && (stat_frames != '1))
        stat_frames <= stat_frames + 16'd1;
      if (load && dec_detected && (stat_corrected != '1))
        stat_corrected <= stat_corrected + 16'd1;
      if (abort_frame && (stat_aborts != '1))
        stat_aborts <= stat_aborts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bch74_serial_decoder.sv
// tb/tb_bch74_serial_decoder.sv - directed self-checking bench for bch74_serial_decoder

module tb_bch74_serial_decoder;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_bit;
  logic       s_sof;
  logic       s_ready;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       m_err_detected;
  logic       m_err_corrected;
`ifdef BCH74_DECODER_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_corrected;
  logic [7:0]  stat_aborts;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int stall_cnt = 0;

  logic [5:0] words[$];  // {corrected, detected, data}
  int         wcyc[$];

  // Hand-computed codewords c[6:0] for data 0..15.
  logic [6:0] cw_tab [16];

  bch74_serial_decoder #(.MSB_FIRST(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_bit           (s_bit),
    .s_sof           (s_sof),
    .s_ready         (s_ready),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_err_detected  (m_err_detected),
`ifdef BCH74_DECODER_STATS_EN
    .stat_frames     (stat_frames),
    .stat_corrected  (stat_corrected),
    .stat_aborts     (stat_aborts),
`endif
    .m_err_corrected (m_err_corrected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change #1 after posedge, so negedge sees the values the next posedge will use.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      words.push_back({m_err_corrected, m_err_detected, m_data});
      wcyc.push_back(cyc);
    end
    if (rst_n && s_valid && !s_ready) stall_cnt = stall_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    int w;
    s_valid = 1'b1;
    s_bit   = b;
    s_sof   = sof;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("s_ready_wait", 32'(w < 100), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_bits(input logic [6:0] cw, input int n);
    for (int k = 0; k < n; k++) send_bit(cw[6-k], k == 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_det"}, 32'(m_err_detected), 32'd0);
    chk({tag, "_corr"}, 32'(m_err_corrected), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    int base;
    int st0;
    logic [6:0] cw;

    cw_tab[0]  = 7'b0000000; cw_tab[1]  = 7'b0001111;
    cw_tab[2]  = 7'b0010011; cw_tab[3]  = 7'b0011100;
    cw_tab[4]  = 7'b0100101; cw_tab[5]  = 7'b0101010;
    cw_tab[6]  = 7'b0110110; cw_tab[7]  = 7'b0111001;
    cw_tab[8]  = 7'b1000110; cw_tab[9]  = 7'b1001001;
    cw_tab[10] = 7'b1010101; cw_tab[11] = 7'b1011010;
    cw_tab[12] = 7'b1100011; cw_tab[13] = 7'b1101100;
    cw_tab[14] = 7'b1110000; cw_tab[15] = 7'b1111111;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_bit   = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b0;
    idle(3);
    chk_zero_outputs("reset");
`ifdef BCH74_DECODER_STATS_EN
    chk("reset_stat_frames", 32'(stat_frames), 32'd0);
    chk("reset_stat_aborts", 32'(stat_aborts), 32'd0);
`endif
    rst_n = 1'b1;
    idle(1);

    // Abort: 4 bits of 1011's frame, then a full sof frame for 0101.
    m_ready = 1'b1;
    base = words.size();
    send_bits(cw_tab[11], 4);
    send_bits(cw_tab[5], 7);
    idle(3);
    chk("abort_count", 32'(words.size() - base), 32'd1);
    chk("abort_word", 32'(words[base]), 32'h05);
`ifdef BCH74_DECODER_STATS_EN
    chk("abort_stat_aborts", 32'(stat_aborts), 32'd1);
    chk("abort_stat_frames", 32'(stat_frames), 32'd1);
    chk("abort_stat_corr", 32'(stat_corrected), 32'd0);
`endif

    // No error, checking one-cycle latency.
    base = words.size();
    send_bits(cw_tab[11], 7);
    chk("lat_m_valid", 32'(m_valid), 32'd1);
    chk("lat_m_data", 32'(m_data), 32'hB);
    chk("lat_det", 32'(m_err_detected), 32'd0);
    idle(2);
    chk("noerr_count", 32'(words.size() - base), 32'd1);
    chk("noerr_word", 32'(words[base]), 32'h0B);
    chk("noerr_drained", 32'(m_valid), 32'd0);

    // Every single-bit error on 1011010 corrects back to 1011 with both flags.
    for (int i = 0; i < 7; i++) begin
      base = words.size();
      cw = cw_tab[11] ^ (7'd1 << i);
      send_bits(cw, 7);
      idle(2);
      chk($sformatf("err%0d_count", i), 32'(words.size() - base), 32'd1);
      chk($sformatf("err%0d_word", i), 32'(words[base]), 32'h3B);
    end
`ifdef BCH74_DECODER_STATS_EN
    chk("err_stat_frames", 32'(stat_frames), 32'd9);
    chk("err_stat_corr", 32'(stat_corrected), 32'd7);
`endif

    // Back-to-back stream of all 16 values.
    base = words.size();
    st0  = stall_cnt;
    for (int d = 0; d < 16; d++) send_bits(cw_tab[d], 7);
    idle(3);
    chk("stream_count", 32'(words.size() - base), 32'd16);
    chk("stream_stalls", 32'(stall_cnt - st0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stream_word%0d", i), 32'(words[base+i]), 32'(i));
      if (i > 0)
        chk($sformatf("stream_gap%0d", i), 32'(wcyc[base+i] - wcyc[base+i-1]), 32'd7);
    end

    // Backpressure: A=1011 held, B=0110 stalls on its 7th bit.
    m_ready = 1'b0;
    base = words.size();
    send_bits(cw_tab[11], 7);
    send_bits(cw_tab[6], 6);
    cw = cw_tab[6];
    s_valid = 1'b1;
    s_bit   = cw[0];
    s_sof   = 1'b0;
    @(negedge clk);
    chk("bp_s_ready_low", 32'(s_ready), 32'd0);
    chk("bp_m_data_a", 32'(m_data), 32'hB);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_s_ready_low2", 32'(s_ready), 32'd0);
    chk("bp_m_valid_hold", 32'(m_valid), 32'd1);
    chk("bp_m_data_hold", 32'(m_data), 32'hB);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_high", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("bp_b_valid", 32'(m_valid), 32'd1);
    chk("bp_b_data", 32'(m_data), 32'h6);
    idle(2);
    chk("bp_count", 32'(words.size() - base), 32'd2);
    chk("bp_word_a", 32'(words[base]), 32'h0B);
    chk("bp_word_b", 32'(words[base+1]), 32'h06);
    chk("bp_no_bubble", 32'(wcyc[base+1] - wcyc[base]), 32'd1);

    // Reset mid-frame.
    send_bits(cw_tab[11], 3);
    rst_n = 1'b0;
    idle(1);
    chk_zero_outputs("rst_mid");
    rst_n = 1'b1;
    base = words.size();
    send_bits(cw_tab[5], 7);
    idle(2);
    chk("rst_mid_count", 32'(words.size() - base), 32'd1);
    chk("rst_mid_word", 32'(words[base]), 32'h05);

    // Reset with m_valid held high.
    m_ready = 1'b0;
    send_bits(cw_tab[9], 7);
    chk("rst_valid_pre", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    idle(1);
    chk_zero_outputs("rst_valid");
`ifdef BCH74_DECODER_STATS_EN
    chk("rst_stat_frames", 32'(stat_frames), 32'd0);
`endif
    rst_n = 1'b1;
    m_ready = 1'b1;
    base = words.size();
    cw = cw_tab[11] ^ 7'b0001000;
    send_bits(cw, 7);
    idle(2);
    chk("rst_valid_count", 32'(words.size() - base), 32'd1);
    chk("rst_valid_word", 32'(words[base]), 32'h3B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bch74_serial_decoder.md
Name: bch74_serial_decoder

Overview:
Bit-serial BCH(7,4) single-error-correcting decoder for the receive end of a serial link fed by the team's parallel BCH(7,4) encoder plus serializer.
- Accumulates the 3-bit syndrome on the fly while the 7 codeword bits arrive.
- Corrects any single-bit error.
- Presents the 4-bit data word on a valid/ready output port with a one-entry output register, so the next frame can stream in while the current result waits.

Parameters:
MSB_FIRST, 1, 1: first serial bit is c[6]; 0: first serial bit is c[0].

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
s_valid  input  1  serial bit valid
s_bit  input  1  serial codeword bit
s_sof  input  1  start of frame; qualified by s_valid; marks first bit of a codeword
s_ready  output  1  decoder accepts the serial bit this cycle
m_valid  output  1  decoded word valid
m_ready  input  1  downstream accepts the word
m_data  output  4  corrected data, equal to corrected c[6:3]
m_err_detected  output  1  nonzero syndrome for this word
m_err_corrected  output  1  a bit was flipped for this word

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Codeword definition:
  - c[6:3] = d[3:0]
  - c2 = d3^d2^d0
  - c1 = d3^d1^d0
  - c0 = d2^d1^d0
- Syndrome {s2,s1,s0}:
  - s2 = c6^c5^c3^c2
  - s1 = c6^c4^c3^c1
  - s0 = c5^c4^c3^c0
- Single-error syndrome to bit position: 110->c6, 101->c5, 011->c4, 111->c3, 100->c2, 010->c1, 001->c0.
- All 7 nonzero syndromes map to a bit, so m_err_corrected == m_err_detected. A flip of c2..c0 leaves m_data unchanged.
- Datapath: syndrome register XOR-accumulates the H column of each accepted bit; a 7-bit shift buffer holds the raw bits; a 3-bit bit_cnt runs 0..6.
- FSM states:
  - IDLE: s_ready=1. A bit with s_valid&&!s_sof is discarded. s_valid&&s_sof loads the bit as index 0, sets syndrome to its column, bit_cnt=1, goes to SHIFT.
  - SHIFT: each accepted bit increments bit_cnt. On the bit with bit_cnt==6:
    - corrected word computed combinationally, including that bit;
    - output register loaded;
    - syndrome cleared;
    - return to IDLE.
  - SHIFT, s_sof on an accepted bit: aborts the partial frame. The bit restarts the frame as index 0 and nothing is emitted.
- Latency: m_valid rises the cycle after the 7th bit is accepted.
- Handshake: m_valid/m_data/flags hold stable while m_valid&&!m_ready. m_valid clears on m_valid&&m_ready unless a new word loads in the same cycle (back-to-back, no bubble).
- Backpressure: s_ready = !(state==SHIFT && bit_cnt==6 && m_valid && !m_ready). Only the 7th bit stalls; bits 0..5 are always accepted.
- Reset, including mid-frame or with m_valid high: state=IDLE, bit_cnt=0, syndrome=0, buffer=0, m_valid=0, m_data=0, m_err_detected=0, m_err_corrected=0. The partial frame is lost.
- Double errors are miscorrected silently (distance-3 code). This is by design and is not flagged.

Optional Feature:
- Macro: BCH74_DECODER_STATS_EN.
- When defined, adds three outputs, each cleared only by reset and each saturating at all-ones (no wrap):
  - stat_frames  output 16, count of words loaded to the output register;
  - stat_corrected  output 16, count of those words with nonzero syndrome;
  - stat_aborts  output 8, count of frames aborted by s_sof in SHIFT.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bch74_pkg: code constants N=7, K=4, R=3; H column table indexed by bit position; syndrome-to-position function; encode function for bench reference models.
- Sub-module bch74_syndrome_corrector: combinational; maps 7-bit word to corrected data, error_detected and error_corrected. Shareable with the parallel decoder.
- FSM, buffer and output register stay in the top.

Test Plan:
- No error: data 1011 -> codeword 1011010 serialized MSB-first with sof on the first bit -> m_valid one cycle after the 7th bit; m_data=1011, detected=0, corrected=0.
- Single errors: for i=0..6 send 1011010^(1<<i), e.g. bit5 -> 1111010 with syndrome 101 -> m_data=1011, detected=1, corrected=1 for every i.
- Back-to-back with m_ready=1: all 16 data values streamed continuously -> 16 words in order, s_ready never low, no bubbles.
- Backpressure: m_ready=0, send frames A=1011 and B=0110 -> s_ready drops on B's 7th bit. Raise m_ready -> A accepted, B loads the next cycle, no bit lost.
- Abort: send 4 bits of a frame, then a new sof frame encoding 0101 -> exactly one word emitted, 0101. With BCH74_DECODER_STATS_EN, stat_aborts=1.
- Reset mid-frame and with m_valid high -> all outputs 0 next cycle. The next full frame decodes correctly.
